// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: NUM_REQ producers share one FIFO push port, each tenure capped at BURST_MAX beats.
// Define FIFO_WR_ARB_STAT_EN to add per-producer saturating beat counters (stat_clr / stat_beats).
module fifo_wr_arb #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int BURST_MAX = 4,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_w_valid,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy
`ifdef FIFO_WR_ARB_STAT_EN
  ,
  input  logic                     stat_clr,
  output logic [NUM_REQ*16-1:0]    stat_beats
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] last_q, last_d;
  logic [3:0]     beat_cnt_q, beat_cnt_d;
  logic           beat_s;
  logic           tenure_end_s;

  // First valid index at or after start, wrapping modulo NUM_REQ.
  function automatic logic [IDW-1:0] pick_next(input logic [NUM_REQ-1:0] vld, input int start);
    logic [IDW-1:0] sel;
    int idx;
    sel = {IDW{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (start + k) % NUM_REQ;
      if (vld[idx]) sel = IDW'(idx);
      else sel = sel;
    end
    return sel;
  endfunction

  // Beat and tenure-end detection for the current owner.
  always_comb begin
    beat_s       = 1'b0;
    tenure_end_s = 1'b0;
    if (state_q == ST_GRANT) begin
      beat_s       = req_valid[grant_q] & ~fifo_full;
      tenure_end_s = ~req_valid[grant_q] | (beat_s & ((beat_cnt_q + 4'd1) == BURST_LIM));
    end else begin
      beat_s       = 1'b0;
      tenure_end_s = 1'b0;
    end
  end

  // Next-state logic; re-arbitration at tenure end happens in the same cycle.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_d = pick_next(req_valid, int'(last_q) + 1);
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (tenure_end_s) begin
          last_d     = grant_q;
          beat_cnt_d = 4'd0;
          if (|req_valid) begin
            grant_d = pick_next(req_valid, int'(grant_q) + 1);
            state_d = ST_GRANT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + {3'b000, beat_s};
        end
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = 4'd0;
      end
    endcase
  end

  // Arbiter state registers; last_id resets to the top index so producer 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= {IDW{1'b0}};
      last_q     <= IDW'(NUM_REQ - 1);
      beat_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Handshake outputs: only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready    = {NUM_REQ{1'b0}};
    fifo_w_valid = 1'b0;
    fifo_data_in = req_data[int'(grant_q)*WIDTH +: WIDTH];
    if (state_q == ST_GRANT) begin
      req_ready[grant_q] = ~fifo_full;
      fifo_w_valid       = beat_s;
    end else begin
      req_ready    = {NUM_REQ{1'b0}};
      fifo_w_valid = 1'b0;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == ST_GRANT);

`ifdef FIFO_WR_ARB_STAT_EN
  logic [15:0] stat_q [NUM_REQ];
  logic [15:0] stat_d [NUM_REQ];

  // Per-producer beat counters; clear wins over counting, counting saturates.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clr) begin
        stat_d[i] = 16'h0000;
      end else if (beat_s && (grant_q == IDW'(i)) && (stat_q[i] != 16'hFFFF)) begin
        stat_d[i] = stat_q[i] + 16'h0001;
      end else begin
        stat_d[i] = stat_q[i];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= 16'h0000;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= stat_d[i];
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    stat_beats = {(NUM_REQ*16){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) stat_beats[i*16 +: 16] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus randomized traffic against a behavioural model.
module tb_fifo_wr_arb;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int BM = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           fifo_full = 1'b0;
  logic           fifo_w_valid;
  logic [W-1:0]   fifo_data_in;
  logic [1:0]     grant_id;
  logic           busy;
`ifdef FIFO_WR_ARB_STAT_EN
  logic           stat_clr = 1'b0;
  logic [N*16-1:0] stat_beats;
`endif

  fifo_wr_arb #(.NUM_REQ(N), .WIDTH(W), .BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_w_valid(fifo_w_valid),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy)
`ifdef FIFO_WR_ARB_STAT_EN
    , .stat_clr(stat_clr), .stat_beats(stat_beats)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner -1 means nobody holds the port.
  int m_owner = -1, m_last = N - 1, m_beats = 0;
  int n_owner = -1, n_last = N - 1, n_beats = 0;
  int m_stat [N];
  int n_stat [N];

  function automatic int rr_pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    bit beat;
    bit done;
    if (!rst_n) begin
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_ready", {60'd0, req_ready}, 64'd0);
      chk("rst_wvalid", {63'd0, fifo_w_valid}, 64'd0);
    end else begin
      beat = (m_owner >= 0) && req_valid[m_owner] && !fifo_full;
      exp_ready = '0;
      if (m_owner >= 0 && !fifo_full) exp_ready[m_owner] = 1'b1;
      chk("busy", {63'd0, busy}, {63'd0, m_owner >= 0});
      chk("ready", {60'd0, req_ready}, {60'd0, exp_ready});
      chk("wvalid", {63'd0, fifo_w_valid}, {63'd0, beat});
      if (m_owner >= 0) chk("grant", {62'd0, grant_id}, 64'(m_owner));
      if (beat) chk("data", {32'd0, fifo_data_in}, {32'd0, req_data[m_owner*W +: W]});
`ifdef FIFO_WR_ARB_STAT_EN
      for (int i = 0; i < N; i++) begin
        chk("stat", {48'd0, stat_beats[i*16 +: 16]}, 64'(m_stat[i]));
        if (stat_clr) n_stat[i] = 0;
        else if (beat && m_owner == i && m_stat[i] < 65535) n_stat[i] = m_stat[i] + 1;
        else n_stat[i] = m_stat[i];
      end
`endif
      n_owner = m_owner; n_last = m_last; n_beats = m_beats;
      if (m_owner < 0) begin
        n_owner = rr_pick(req_valid, m_last + 1);
      end else begin
        done = !req_valid[m_owner] || (beat && m_beats + 1 == BM);
        if (done) begin
          n_last  = m_owner;
          n_beats = 0;
          n_owner = rr_pick(req_valid, m_owner + 1);
        end else begin
          n_beats = m_beats + (beat ? 1 : 0);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner <= -1; m_last <= N - 1; m_beats <= 0;
      for (int i = 0; i < N; i++) m_stat[i] <= 0;
    end else begin
      m_owner <= n_owner; m_last <= n_last; m_beats <= n_beats;
      for (int i = 0; i < N; i++) m_stat[i] <= n_stat[i];
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int exp_g [9];
    int k, first, last;
    for (int i = 0; i < N; i++) begin m_stat[i] = 0; n_stat[i] = 0; end
    exp_g = '{0, 0, 0, 0, 2, 2, 2, 2, 0};

    // Round-robin between producers 0 and 2 with full bursts.
    do_reset();
    req_valid = 4'b0101;
    @(negedge clk);
    chk("p34_idle_busy", {63'd0, busy}, 64'd0);
    for (int c = 0; c < 9; c++) begin
      nxt(); @(negedge clk);
      chk("p34_grant", {62'd0, grant_id}, 64'(exp_g[c]));
      chk("p34_busy", {63'd0, busy}, 64'd1);
      chk("p34_beat", {63'd0, fifo_w_valid}, 64'd1);
    end

    // Sole requester: ten words in order with no gap cycles.
    nxt(); do_reset();
    k = 0; first = -1; last = -1;
    req_valid = 4'b1000; req_data[3*W +: W] = 32'h100;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (fifo_w_valid) begin
        chk("p35_data", {32'd0, fifo_data_in}, 64'(32'h100 + k));
        if (first < 0) first = c;
        last = c;
        k++;
      end
      nxt();
      req_data[3*W +: W] = W'(32'h100 + k);
      req_valid = (k < 10) ? 4'b1000 : 4'b0000;
    end
    chk("p35_count", 64'(k), 64'd10);
    chk("p35_nogap", 64'(last - first), 64'd9);

    // FIFO-full stall mid-burst for owner 1.
    do_reset();
    req_valid = 4'b0110;
    @(negedge clk); nxt();
    @(negedge clk); chk("p36_b1", {62'd0, grant_id}, 64'd1); nxt();
    @(negedge clk); chk("p36_b2", {63'd0, fifo_w_valid}, 64'd1); nxt();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("p36_stall_wv", {63'd0, fifo_w_valid}, 64'd0);
      chk("p36_stall_g", {62'd0, grant_id}, 64'd1);
      nxt();
      if (c == 4) fifo_full = 1'b0;
    end
    @(negedge clk); chk("p36_b3", {62'd0, grant_id, fifo_w_valid}, 64'd3); nxt();
    @(negedge clk); chk("p36_b4", {62'd0, grant_id, fifo_w_valid}, 64'd3); nxt();
    @(negedge clk); chk("p36_handover", {62'd0, grant_id}, 64'd2);

    // Owner 2 drops after one beat; producer 3 takes over next cycle.
    nxt(); do_reset();
    req_valid = 4'b1100;
    @(negedge clk); nxt();
    @(negedge clk); chk("p37_g2", {62'd0, grant_id, fifo_w_valid}, 64'h5); nxt();
    req_valid = 4'b1000;
    @(negedge clk); chk("p37_drop", {63'd0, fifo_w_valid}, 64'd0); nxt();
    @(negedge clk); chk("p37_g3", {62'd0, grant_id, fifo_w_valid}, 64'h7);

    // Reset in the middle of a tenure.
    nxt(); do_reset();
    req_valid = 4'b0100;
    @(negedge clk); nxt();
    @(negedge clk); chk("p38_g2", {62'd0, grant_id}, 64'd2);
    nxt(); rst_n = 1'b0; #1;
    chk("p38_rst_out", {58'd0, req_ready, fifo_w_valid, busy}, 64'd0);
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); chk("p38_idle", {63'd0, busy}, 64'd0); nxt();
    @(negedge clk); chk("p38_first", {62'd0, grant_id}, 64'd0);

    // Randomized traffic with occasional resets.
    nxt();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) req_valid[i] = ~req_valid[i];
        req_data[i*W +: W] = $urandom;
      end
      fifo_full = ($urandom_range(0, 4) == 0);
`ifdef FIFO_WR_ARB_STAT_EN
      stat_clr = ($urandom_range(0, 99) == 0);
`endif
      nxt();
    end
    rst_n = 1'b1;

`ifdef FIFO_WR_ARB_STAT_EN
    do_reset();
    stat_clr = 1'b0;
    req_valid = 4'b0001;
    repeat (70010) @(posedge clk);
    @(negedge clk); chk("stat_sat", {48'd0, stat_beats[15:0]}, 64'hFFFF);
    nxt(); stat_clr = 1'b1;
    @(negedge clk); nxt(); stat_clr = 1'b0;
    @(negedge clk); chk("stat_clr", {48'd0, stat_beats[15:0]}, 64'd0);
`endif

    nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
